// File: rtl/ex_stage_pkg.sv
// Shared types and constants for the execute stage and its divider.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ex_stage_pkg;

  localparam int DS_TO_ES_BUS_W = 152;
  localparam int ES_TO_MS_BUS_W = 71;
  localparam int ES_FWD_BUS_W   = 7;

  // alu_op one-hot bit positions
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  // div_op one-hot bit positions
  localparam int DIV_DIV  = 0;
  localparam int DIV_DIVU = 1;
  localparam int DIV_MOD  = 2;
  localparam int DIV_MODU = 3;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Decode-to-execute bus, MSB first
  typedef struct packed {
    logic [11:0] alu_op;
    logic [3:0]  div_op;
    logic        mem_we;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] rkd_value;
    logic [31:0] pc;
  } ds_to_es_t;

  // Magnitude of a value that is two's complement only when sgn is set
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Handshake and bus bundle around the execute stage (decode in, memory out, data SRAM).
// Latency: n/a (wires only).
// Backpressure: valid/allowin pairs on both pipeline sides.
interface ex_stage_if;
  import ex_stage_pkg::*;

  logic                      ds_to_es_valid;
  logic [DS_TO_ES_BUS_W-1:0] ds_to_es_bus;
  logic                      es_allowin;
  logic                      ms_allowin;
  logic                      es_to_ms_valid;
  logic [ES_TO_MS_BUS_W-1:0] es_to_ms_bus;
  logic [ES_FWD_BUS_W-1:0]   es_fwd_bus;
  logic                      data_sram_en;
  logic [3:0]                data_sram_we;
  logic [31:0]               data_sram_addr;
  logic [31:0]               data_sram_wdata;

  // master: the execute stage itself
  modport master (
    input  ds_to_es_valid, ds_to_es_bus, ms_allowin,
    output es_allowin, es_to_ms_valid, es_to_ms_bus, es_fwd_bus,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );

  // slave: the surrounding pipeline / memory
  modport slave (
    output ds_to_es_valid, ds_to_es_bus, ms_allowin,
    input  es_allowin, es_to_ms_valid, es_to_ms_bus, es_fwd_bus,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );

endinterface

// File: rtl/ex_stage_div_unit.sv
// Iterative 32-bit restoring divider (div/divu/mod/modu) with IDLE/BUSY/DONE FSM.
// Latency: start seen in IDLE, 32 BUSY cycles, result valid in DONE.
// Backpressure: holds DONE and a stable result until ack.
module div_unit
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        is_signed,
  input  logic        op_mod,
  input  logic        ack,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] result
);

  div_state_e  state, state_nxt;
  logic [5:0]  count;
  logic [31:0] quo, rem, dvs, dvd_orig;
  logic        q_neg, r_neg, dvs_zero;
  logic [32:0] rem_sh, diff;
  logic [31:0] quo_step, rem_step, quo_fix, rem_fix;
  logic        last_step;

  assign last_step = (count == 6'd31);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!resetn) state <= DIV_IDLE;
    else         state <= state_nxt;
  end

  // FSM next state: one pass through BUSY per operation, DONE waits for ack
  always_comb begin
    state_nxt = state;
    unique case (state)
      DIV_IDLE: if (start)     state_nxt = DIV_BUSY;
      DIV_BUSY: if (last_step) state_nxt = DIV_DONE;
      DIV_DONE: if (ack)       state_nxt = DIV_IDLE;
      default:                 state_nxt = DIV_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    done = (state == DIV_DONE);
  end

  // One shift-subtract step plus the sign/zero corrections for the final step
  always_comb begin
    rem_sh = {rem, quo[31]};
    diff   = rem_sh - {1'b0, dvs};
    if (diff[32]) begin
      rem_step = rem_sh[31:0];
      quo_step = {quo[30:0], 1'b0};
    end else begin
      rem_step = diff[31:0];
      quo_step = {quo[30:0], 1'b1};
    end
    quo_fix = q_neg ? -quo_step : quo_step;
    rem_fix = r_neg ? -rem_step : rem_step;
    // A zero divisor yields all-ones quotient and the untouched dividend
    if (dvs_zero) begin
      quo_fix = 32'hFFFF_FFFF;
      rem_fix = dvd_orig;
    end
  end

  // Operand capture on start, iteration in BUSY, result latched on the last step
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count    <= 6'd0;
      quo      <= 32'd0;
      rem      <= 32'd0;
      dvs      <= 32'd0;
      dvd_orig <= 32'd0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      dvs_zero <= 1'b0;
      result   <= 32'd0;
    end else begin
      unique case (state)
        DIV_IDLE: if (start) begin
          quo      <= abs32(dividend, is_signed);
          dvs      <= abs32(divisor, is_signed);
          rem      <= 32'd0;
          count    <= 6'd0;
          q_neg    <= is_signed & (dividend[31] ^ divisor[31]);
          r_neg    <= is_signed & dividend[31];
          dvs_zero <= (divisor == 32'd0);
          dvd_orig <= dividend;
        end
        DIV_BUSY: begin
          quo   <= quo_step;
          rem   <= rem_step;
          count <= count + 6'd1;
          if (last_step) result <= op_mod ? rem_fix : quo_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: latches decode bus, ALU, data-SRAM request, optional divider (macro DIV_EN).
// Latency: 1 cycle for ALU ops; 33 cycles for divides when DIV_EN is defined.
// Backpressure: es_allowin drops while the held instruction is not ready or ms_allowin is low.
module ex_stage
  import ex_stage_pkg::*;
(
  input logic        clk,
  input logic        resetn,
  ex_stage_if.master pipe
);

  ds_to_es_t   es_r;
  logic        es_valid;
  logic        es_ready_go;
  logic        es_allowin;
  logic        is_div;
  logic [31:0] src1, src2;
  logic [31:0] alu_res, div_res, es_result;

  assign src1   = es_r.src1;
  assign src2   = es_r.src2;
  assign is_div = |es_r.div_op;

  assign es_allowin = !es_valid || (es_ready_go && pipe.ms_allowin);

  // Stage occupancy
  always_ff @(posedge clk) begin
    if (!resetn)         es_valid <= 1'b0;
    else if (es_allowin) es_valid <= pipe.ds_to_es_valid;
  end

  // Instruction fields captured on acceptance
  always_ff @(posedge clk) begin
    if (!resetn)                                  es_r <= '0;
    else if (pipe.ds_to_es_valid && es_allowin)   es_r <= ds_to_es_t'(pipe.ds_to_es_bus);
  end

  // Single-cycle ALU; alu_op is one-hot so the terms are OR-merged
  always_comb begin
    alu_res = 32'd0;
    if (es_r.alu_op[ALU_ADD])  alu_res = alu_res | (src1 + src2);
    if (es_r.alu_op[ALU_SUB])  alu_res = alu_res | (src1 - src2);
    if (es_r.alu_op[ALU_SLT])  alu_res = alu_res | {31'd0, ($signed(src1) < $signed(src2))};
    if (es_r.alu_op[ALU_SLTU]) alu_res = alu_res | {31'd0, (src1 < src2)};
    if (es_r.alu_op[ALU_AND])  alu_res = alu_res | (src1 & src2);
    if (es_r.alu_op[ALU_NOR])  alu_res = alu_res | ~(src1 | src2);
    if (es_r.alu_op[ALU_OR])   alu_res = alu_res | (src1 | src2);
    if (es_r.alu_op[ALU_XOR])  alu_res = alu_res | (src1 ^ src2);
    if (es_r.alu_op[ALU_SLL])  alu_res = alu_res | (src1 << src2[4:0]);
    if (es_r.alu_op[ALU_SRL])  alu_res = alu_res | (src1 >> src2[4:0]);
    if (es_r.alu_op[ALU_SRA])  alu_res = alu_res | $unsigned($signed(src1) >>> src2[4:0]);
    if (es_r.alu_op[ALU_LUI])  alu_res = alu_res | src2;
  end

`ifdef DIV_EN
  logic div_done;

  div_unit u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (es_valid & is_div),
    .is_signed (es_r.div_op[DIV_DIV] | es_r.div_op[DIV_MOD]),
    .op_mod    (es_r.div_op[DIV_MOD] | es_r.div_op[DIV_MODU]),
    .ack       (pipe.ms_allowin),
    .dividend  (src1),
    .divisor   (src2),
    .done      (div_done),
    .result    (div_res)
  );

  assign es_ready_go = !is_div || div_done;
`else
  // Without the divider, divide ops retire immediately with a zero result
  assign div_res     = 32'd0;
  assign es_ready_go = 1'b1;
`endif

  assign es_result = is_div ? div_res : alu_res;

  assign pipe.es_allowin     = es_allowin;
  assign pipe.es_to_ms_valid = es_valid && es_ready_go;
  assign pipe.es_to_ms_bus   = {es_r.res_from_mem, es_r.gr_we, es_r.dest, es_result, es_r.pc};
  assign pipe.es_fwd_bus     = {es_valid & es_r.gr_we, es_r.dest, es_r.res_from_mem};

  // Word-only data SRAM; stores fire only in the cycle the memory stage takes them
  assign pipe.data_sram_en    = es_valid & (es_r.res_from_mem | es_r.mem_we);
  assign pipe.data_sram_we    = {4{es_valid & es_r.mem_we & pipe.ms_allowin}};
  assign pipe.data_sram_addr  = alu_res;
  assign pipe.data_sram_wdata = es_r.rkd_value;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: reset, store window, ALU burst, divides, hold, mid-divide reset.
// Latency: checks 1-cycle ALU and 33-cycle divide (or 1-cycle zero result without DIV_EN).
// Backpressure: drives ms_allowin low to check stalls and single transfer.
module tb_ex_stage;

  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_err;

  localparam logic [11:0] OP_ADD  = 12'h001;
  localparam logic [11:0] OP_SUB  = 12'h002;
  localparam logic [11:0] OP_SLT  = 12'h004;
  localparam logic [11:0] OP_SLTU = 12'h008;
  localparam logic [11:0] OP_AND  = 12'h010;
  localparam logic [11:0] OP_NOR  = 12'h020;
  localparam logic [11:0] OP_OR   = 12'h040;
  localparam logic [11:0] OP_XOR  = 12'h080;
  localparam logic [11:0] OP_SLL  = 12'h100;
  localparam logic [11:0] OP_SRL  = 12'h200;
  localparam logic [11:0] OP_SRA  = 12'h400;
  localparam logic [11:0] OP_LUI  = 12'h800;
  localparam logic [3:0]  DV_DIV  = 4'h1;
  localparam logic [3:0]  DV_DIVU = 4'h2;
  localparam logic [3:0]  DV_MOD  = 4'h4;

`ifdef DIV_EN
  localparam int DLAT = 33;
`else
  localparam int DLAT = 0;
`endif

  ex_stage_if u_if ();

  ex_stage dut (
    .clk    (clk),
    .resetn (resetn),
    .pipe   (u_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge (input drive point)
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [151:0] mk(input logic [11:0] alu, input logic [3:0] dv,
                                      input logic mwe, input logic rfm, input logic gwe,
                                      input logic [4:0] dst, input logic [31:0] s1,
                                      input logic [31:0] s2, input logic [31:0] rkd,
                                      input logic [31:0] pc);
    return {alu, dv, mwe, rfm, gwe, dst, s1, s2, rkd, pc};
  endfunction

  function automatic logic [31:0] dx(input logic [31:0] v);
`ifdef DIV_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  function automatic logic [31:0] res_of();
    return u_if.es_to_ms_bus[63:32];
  endfunction

  task automatic issue(input logic [151:0] b);
    u_if.ds_to_es_valid = 1'b1;
    u_if.ds_to_es_bus   = b;
    cyc();
    u_if.ds_to_es_valid = 1'b0;
  endtask

  // Issue a divide, measure cycles to es_to_ms_valid, check allowin stays low and the result
  task automatic run_div(input string tag, input logic [151:0] b, input logic [31:0] exp);
    int   lat;
    logic open_seen;
    issue(b);
    #2;
    lat       = 0;
    open_seen = 1'b0;
    while (!u_if.es_to_ms_valid && lat < 60) begin
      if (u_if.es_allowin) open_seen = 1'b1;
      cyc();
      #2;
      lat++;
    end
    chk({tag, "_lat"}, lat, DLAT);
    chk({tag, "_allowin"}, 32'(open_seen), 32'd0);
    chk({tag, "_res"}, res_of(), dx(exp));
  endtask

  logic [11:0] v_op [11];
  logic [31:0] v_a  [11];
  logic [31:0] v_b  [11];
  logic [31:0] v_e  [11];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int nout;
    int xfers;
    n_cmp = 0;
    n_err = 0;

    v_op[0]  = OP_SUB;  v_a[0]  = 32'd3;         v_b[0]  = 32'd10;        v_e[0]  = 32'hFFFFFFF9;
    v_op[1]  = OP_SLT;  v_a[1]  = 32'hFFFFFFFF;  v_b[1]  = 32'd1;         v_e[1]  = 32'd1;
    v_op[2]  = OP_SLTU; v_a[2]  = 32'hFFFFFFFF;  v_b[2]  = 32'd1;         v_e[2]  = 32'd0;
    v_op[3]  = OP_AND;  v_a[3]  = 32'hF0F0F0F0;  v_b[3]  = 32'hFF00FF00;  v_e[3]  = 32'hF000F000;
    v_op[4]  = OP_NOR;  v_a[4]  = 32'h0F0F0000;  v_b[4]  = 32'h00000F0F;  v_e[4]  = 32'hF0F0F0F0;
    v_op[5]  = OP_OR;   v_a[5]  = 32'h12340000;  v_b[5]  = 32'h00005678;  v_e[5]  = 32'h12345678;
    v_op[6]  = OP_XOR;  v_a[6]  = 32'hAAAAAAAA;  v_b[6]  = 32'hFFFF0000;  v_e[6]  = 32'h5555AAAA;
    v_op[7]  = OP_SLL;  v_a[7]  = 32'd1;         v_b[7]  = 32'h24;        v_e[7]  = 32'h10;
    v_op[8]  = OP_SRL;  v_a[8]  = 32'h80000000;  v_b[8]  = 32'd31;        v_e[8]  = 32'd1;
    v_op[9]  = OP_SRA;  v_a[9]  = 32'h80000000;  v_b[9]  = 32'd4;         v_e[9]  = 32'hF8000000;
    v_op[10] = OP_LUI;  v_a[10] = 32'h1234;      v_b[10] = 32'hABCD0000;  v_e[10] = 32'hABCD0000;

    // Reset held for two edges with decode already offering an add
    resetn              = 1'b0;
    u_if.ms_allowin     = 1'b1;
    u_if.ds_to_es_valid = 1'b1;
    u_if.ds_to_es_bus   = mk(OP_ADD, 4'd0, 1'b0, 1'b0, 1'b1, 5'd3, 32'd3, 32'd4, 32'd0, 32'h1C000000);
    repeat (2) begin
      cyc();
      #2;
      chk("rst_out_vld", 32'(u_if.es_to_ms_valid), 32'd0);
      chk("rst_sram_en", 32'(u_if.data_sram_en), 32'd0);
      chk("rst_sram_we", 32'(u_if.data_sram_we), 32'd0);
      chk("rst_fwd_vld", 32'(u_if.es_fwd_bus[6]), 32'd0);
    end
    resetn = 1'b1;
    cyc();
    u_if.ds_to_es_valid = 1'b0;
    #2;
    chk("add_vld", 32'(u_if.es_to_ms_valid), 32'd1);
    chk("add_res", res_of(), 32'd7);
    chk("add_pc", u_if.es_to_ms_bus[31:0], 32'h1C000000);
    chk("add_fwd", 32'(u_if.es_fwd_bus), 32'h46);

    // Store held by memory stage for two cycles
    issue(mk(OP_ADD, 4'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h100, 32'd4, 32'hDEADBEEF, 32'h1C000004));
    u_if.ms_allowin = 1'b0;
    #2;
    chk("st0_en", 32'(u_if.data_sram_en), 32'd1);
    chk("st0_we", 32'(u_if.data_sram_we), 32'd0);
    chk("st0_addr", u_if.data_sram_addr, 32'h104);
    chk("st0_wdata", u_if.data_sram_wdata, 32'hDEADBEEF);
    cyc();
    #2;
    chk("st1_en", 32'(u_if.data_sram_en), 32'd1);
    chk("st1_we", 32'(u_if.data_sram_we), 32'd0);
    chk("st1_addr", u_if.data_sram_addr, 32'h104);
    cyc();
    u_if.ms_allowin = 1'b1;
    #2;
    chk("st2_en", 32'(u_if.data_sram_en), 32'd1);
    chk("st2_we", 32'(u_if.data_sram_we), 32'hF);
    chk("st2_addr", u_if.data_sram_addr, 32'h104);
    cyc();
    #2;
    chk("st3_we", 32'(u_if.data_sram_we), 32'd0);
    chk("st3_en", 32'(u_if.data_sram_en), 32'd0);

    // Back-to-back ALU burst, one instruction per cycle
    u_if.ds_to_es_valid = 1'b1;
    u_if.ds_to_es_bus   = mk(v_op[0], 4'd0, 1'b0, 1'b0, 1'b1, 5'd1, v_a[0], v_b[0], 32'd0, 32'h0);
    for (int i = 0; i < 11; i++) begin
      cyc();
      if (i + 1 < 11)
        u_if.ds_to_es_bus = mk(v_op[i+1], 4'd0, 1'b0, 1'b0, 1'b1, 5'd1, v_a[i+1], v_b[i+1], 32'd0, 32'h0);
      else
        u_if.ds_to_es_valid = 1'b0;
      #2;
      chk($sformatf("alu%0d_vld", i), 32'(u_if.es_to_ms_valid), 32'd1);
      chk($sformatf("alu%0d_res", i), res_of(), v_e[i]);
    end

    // Divides, issued back to back
    run_div("div_m7_2",   mk(12'd0, DV_DIV,  1'b0, 1'b0, 1'b1, 5'd4, 32'hFFFFFFF9, 32'd2, 32'd0, 32'h0), 32'hFFFFFFFD);
    run_div("mod_m7_2",   mk(12'd0, DV_MOD,  1'b0, 1'b0, 1'b1, 5'd4, 32'hFFFFFFF9, 32'd2, 32'd0, 32'h0), 32'hFFFFFFFF);
    run_div("divu_5_0",   mk(12'd0, DV_DIVU, 1'b0, 1'b0, 1'b1, 5'd4, 32'd5, 32'd0, 32'd0, 32'h0), 32'hFFFFFFFF);
    run_div("mod_min_m1", mk(12'd0, DV_MOD,  1'b0, 1'b0, 1'b1, 5'd4, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h0), 32'd0);
    run_div("div_min_m1", mk(12'd0, DV_DIV,  1'b0, 1'b0, 1'b1, 5'd4, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h0), 32'h80000000);

    // Divide completing while the memory stage stalls for five cycles
    cyc();
    u_if.ms_allowin = 1'b0;
    run_div("div_hold", mk(12'd0, DV_DIV, 1'b0, 1'b0, 1'b1, 5'd6, 32'd100, 32'hFFFFFFF9, 32'd0, 32'h0), 32'hFFFFFFF2);
    repeat (5) begin
      cyc();
      #2;
      chk("hold_vld", 32'(u_if.es_to_ms_valid), 32'd1);
      chk("hold_res", res_of(), dx(32'hFFFFFFF2));
    end
    cyc();
    u_if.ms_allowin = 1'b1;
    xfers = 0;
    repeat (4) begin
      #2;
      if (u_if.es_to_ms_valid && u_if.ms_allowin) xfers++;
      cyc();
    end
    chk("hold_xfers", xfers, 32'd1);

    // Reset pulsed in the tenth busy cycle abandons the divide
    issue(mk(12'd0, DV_DIVU, 1'b0, 1'b0, 1'b1, 5'd7, 32'd100, 32'd7, 32'd0, 32'h0));
    repeat (10) cyc();
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    #2;
    chk("rstmid_fwd_vld", 32'(u_if.es_fwd_bus[6]), 32'd0);
    chk("rstmid_out_vld", 32'(u_if.es_to_ms_valid), 32'd0);
    chk("rstmid_allowin", 32'(u_if.es_allowin), 32'd1);
    nout = 0;
    repeat (40) begin
      cyc();
      #2;
      if (u_if.es_to_ms_valid) nout++;
    end
    chk("rstmid_no_out", nout, 32'd0);
    run_div("divu_100_7", mk(12'd0, DV_DIVU, 1'b0, 1'b0, 1'b1, 5'd7, 32'd100, 32'd7, 32'd0, 32'h0), 32'd14);
    cyc();
    #2;
    chk("drain_vld", 32'(u_if.es_to_ms_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
